// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared constants, types and helpers for the fetch aligner.
//             The halfword buffer is three deep when compressed instructions
//             are enabled (FETCH_RVC_EN defined); otherwise it is two deep.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

`ifdef FETCH_RVC_EN
   localparam int HW_BUF_DEPTH = 3;
`else
   localparam int HW_BUF_DEPTH = 2;
`endif

   // Instruction handed to decode.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        compressed;
   } fetch_out_t;

   // A halfword starts a 16-bit instruction unless its low two bits are 11.
   function automatic logic isCompressed(input logic [15:0] hw);
      return (hw[1:0] != 2'b11);
   endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_hw_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_hw_buffer
//  Purpose  : Small in-order halfword queue. Each cycle it can pop 0/1/2
//             entries from the head and push 0/1/2 entries at the tail
//             (pop is applied before push). Flush empties the queue.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_flush       - discard all entries (wins over push/pop)
//             i_push_cnt    - halfwords to append (0..2)
//             i_push_data   - [15:0] appended first, [31:16] second
//             i_pop_cnt     - halfwords to remove from the head (0..2)
//             o_hw0, o_hw1  - head entry and the one behind it
//             o_count       - number of valid entries
//  Revision : 1.0  initial release
// ============================================================================
module fetch_hw_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_flush,
   input  logic [1:0]  i_push_cnt,
   input  logic [31:0] i_push_data,
   input  logic [1:0]  i_pop_cnt,
   output logic [15:0] o_hw0,
   output logic [15:0] o_hw1,
   output logic [1:0]  o_count
);

   logic [15:0] r_buf     [HW_BUF_DEPTH];
   logic [15:0] w_buf_nxt [HW_BUF_DEPTH];
   logic [1:0]  r_count;
   logic [1:0]  w_count_nxt;
   logic [1:0]  w_base;

   always_comb begin
      // Tail position once the popped entries have left the head.
      w_base = r_count - i_pop_cnt;
      for (int k = 0; k < HW_BUF_DEPTH; k++) begin
         w_buf_nxt[k] = r_buf[k];
         // Survivors slide toward the head by the pop amount.
         for (int j = 0; j < HW_BUF_DEPTH; j++) begin
            if (j == k + int'(i_pop_cnt)) begin
               w_buf_nxt[k] = r_buf[j];
            end
         end
         if ((i_push_cnt != 2'd0) && (k == int'(w_base))) begin
            w_buf_nxt[k] = i_push_data[15:0];
         end
         if ((i_push_cnt == 2'd2) && (k == int'(w_base) + 1)) begin
            w_buf_nxt[k] = i_push_data[31:16];
         end
      end
      w_count_nxt = w_base + i_push_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         for (int k = 0; k < HW_BUF_DEPTH; k++) begin
            r_buf[k] <= 16'h0000;
         end
      end else if (i_flush) begin
         // Entry contents are left as-is; only the count matters.
         r_count <= 2'd0;
      end else begin
         r_count <= w_count_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   assign o_hw0   = r_buf[0];
   assign o_hw1   = r_buf[1];
   assign o_count = r_count;

endmodule : fetch_hw_buffer
`default_nettype wire

// File: rtl/fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_aligner
//  Purpose  : Instruction-fetch stage. Issues word-aligned requests to
//             instruction memory, buffers returned halfwords and presents one
//             aligned 16/32-bit instruction per cycle to decode, with its PC.
//             A redirect flushes the buffer and drops the stale response of a
//             request still in flight.
//  Config   : FETCH_RVC_EN - when defined, compressed (16-bit) instructions
//             are recognised and redirects may target odd halfwords. When
//             undefined every instruction is 32-bit and redirect targets are
//             forced word aligned.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             redirectValid/Pc      - control-flow redirect from the PC unit
//             reqValid/Ready/Addr   - memory request channel
//             rspValid/rspData      - in-order memory read data
//             instrValid/Ready      - decode handshake
//             instr/instrPc/instrCompressed - instruction presented to decode
//  Revision : 1.0  initial release
// ============================================================================
module fetch_aligner
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc,
   output logic        reqValid,
   input  logic        reqReady,
   output logic [31:0] reqAddr,
   input  logic        rspValid,
   input  logic [31:0] rspData,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instr,
   output logic [31:0] instrPc,
   output logic        instrCompressed
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0] r_fetch_addr;
   logic [31:0] r_instr_pc;
   logic        r_outstanding;
   logic        r_drop_next;

   logic [15:0] w_hw0;
   logic [15:0] w_hw1;
   logic [1:0]  w_count;

   logic        w_has_room;
   logic        w_is_c;
   logic        w_skip;
   logic        w_req_fire;
   logic        w_rsp_take;
   logic        w_consume;
   logic [1:0]  w_push_cnt;
   logic [31:0] w_push_data;
   logic [1:0]  w_pop_cnt;
   logic        w_out_valid;
   fetch_out_t  w_out;

   // ------------------------------------------------------------------------
   // Build-dependent pieces
   // ------------------------------------------------------------------------
`ifdef FETCH_RVC_EN
   localparam logic [31:0] c_redirect_mask = 32'hFFFF_FFFE;

   logic r_skip_half;

   // Room for one full word: at most one halfword may already be queued.
   assign w_has_room  = (w_count <= 2'd1);
   assign w_is_c      = isCompressed(w_hw0);
   assign w_skip      = r_skip_half;
   assign w_push_data = w_skip ? {16'h0000, rspData[31:16]} : rspData;

   // Set when the target PC points at the upper halfword of its word; the
   // lower halfword of the first returned word is then not part of the
   // instruction stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_skip_half <= RESET_PC[1];
      end else if (redirectValid) begin
         r_skip_half <= redirectPc[1];
      end else if (w_rsp_take) begin
         r_skip_half <= 1'b0;
      end
   end
`else
   localparam logic [31:0] c_redirect_mask = 32'hFFFF_FFFC;

   assign w_has_room  = (w_count == 2'd0);
   assign w_is_c      = 1'b0;
   assign w_skip      = 1'b0;
   assign w_push_data = rspData;
`endif

   // ------------------------------------------------------------------------
   // Memory request / response control
   // ------------------------------------------------------------------------
   assign reqValid   = !rst && !redirectValid && !r_outstanding && w_has_room;
   assign reqAddr    = r_fetch_addr;
   assign w_req_fire = reqValid && reqReady;

   // A response is only meaningful against an outstanding request; the one
   // that lands in a redirect cycle or is marked for dropping is discarded.
   assign w_rsp_take = rspValid && r_outstanding && !r_drop_next && !redirectValid;
   assign w_push_cnt = !w_rsp_take ? 2'd0 : (w_skip ? 2'd1 : 2'd2);

   // ------------------------------------------------------------------------
   // Instruction presentation (pure function of registered state)
   // ------------------------------------------------------------------------
   always_comb begin
      w_out_valid      = w_is_c ? (w_count >= 2'd1) : (w_count >= 2'd2);
      w_out.instr      = w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
      w_out.pc         = r_instr_pc;
      // Qualified by valid so an empty buffer never reports compressed.
      w_out.compressed = w_is_c && w_out_valid;
   end

   assign instrValid      = w_out_valid;
   assign instr           = w_out.instr;
   assign instrPc         = w_out.pc;
   assign instrCompressed = w_out.compressed;

   // A handshake coinciding with a redirect is not taken.
   assign w_consume = w_out_valid && instrReady && !redirectValid;
   assign w_pop_cnt = !w_consume ? 2'd0 : (w_is_c ? 2'd1 : 2'd2);

   fetch_hw_buffer u_hw_buffer (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (redirectValid),
      .i_push_cnt  (w_push_cnt),
      .i_push_data (w_push_data),
      .i_pop_cnt   (w_pop_cnt),
      .o_hw0       (w_hw0),
      .o_hw1       (w_hw1),
      .o_count     (w_count)
   );

   // ------------------------------------------------------------------------
   // Address, PC and in-flight tracking
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_addr  <= RESET_PC & 32'hFFFF_FFFC;
         r_instr_pc    <= RESET_PC;
         r_outstanding <= 1'b0;
         r_drop_next   <= 1'b0;
      end else if (redirectValid) begin
         r_fetch_addr  <= redirectPc & 32'hFFFF_FFFC;
         r_instr_pc    <= redirectPc & c_redirect_mask;
         // If the old request has not answered yet, its answer is stale.
         r_drop_next   <= r_outstanding && !rspValid;
         r_outstanding <= r_outstanding && !rspValid;
      end else begin
         if (w_req_fire) begin
            r_outstanding <= 1'b1;
            r_fetch_addr  <= r_fetch_addr + 32'd4;
         end else if (rspValid && r_outstanding) begin
            r_outstanding <= 1'b0;
            r_drop_next   <= 1'b0;
         end
         if (w_consume) begin
            r_instr_pc <= r_instr_pc + (w_is_c ? 32'd2 : 32'd4);
         end
      end
   end

endmodule : fetch_aligner
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_aligner
//  Purpose  : Self-checking bench for fetch_aligner. A memory model answers
//             accepted requests after a programmable latency; expected
//             instructions are queued when a scenario is launched and popped
//             on every decode handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        reqValid;
   logic        reqReady;
   logic [31:0] reqAddr;
   logic        rspValid;
   logic [31:0] rspData;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic        instrCompressed;

   always #5 clk = ~clk;

   fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirectValid   (redirectValid),
      .redirectPc      (redirectPc),
      .reqValid        (reqValid),
      .reqReady        (reqReady),
      .reqAddr         (reqAddr),
      .rspValid        (rspValid),
      .rspData         (rspData),
      .instrValid      (instrValid),
      .instrReady      (instrReady),
      .instr           (instr),
      .instrPc         (instrPc),
      .instrCompressed (instrCompressed)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        c;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0]       base;
      logic [31:0]       ereq;
      logic [3:0][31:0]  w;
      logic [1:0]        n;
      logic [2:0][31:0]  epc;
      logic [2:0][31:0]  ein;
      logic [2:0]        ec;
   } vec_t;

   exp_t        exp_q  [$];
   pend_t       pend_q [$];
   logic [31:0] req_log[$];
   logic [31:0] mem    [0:1023];
   vec_t        tbl    [4];

   int   cyc;
   int   mem_lat;
   int   n_checks;
   int   n_errors;
   logic auto_stop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, base, ereq, w0, w1, w2, w3,
                               input logic [1:0]  n,
                               input logic [31:0] p0, i0, input logic c0,
                               input logic [31:0] p1, i1, input logic c1,
                               input logic [31:0] p2, i2, input logic c2);
      vec_t v;
      v.pc   = pc;
      v.base = base;
      v.ereq = ereq;
      v.w    = {w3, w2, w1, w0};
      v.n    = n;
      v.epc  = {p2, p1, p0};
      v.ein  = {i2, i1, i0};
      v.ec   = {c2, c1, c0};
      return v;
   endfunction

   function automatic logic [31:0] log_at(input int i);
      return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins, input logic c);
      exp_t e;
      e.pc = pc; e.instr = ins; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic mem_put(input logic [31:0] addr, input logic [31:0] data);
      mem[addr[11:2]] = data;
   endtask

   // One clock cycle: observe at the falling edge, then advance the memory
   // model just after the rising edge.
   task automatic tick();
      exp_t  e;
      pend_t p;
      @(negedge clk);
      if (!rst && instrValid && instrReady) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_instr: got pc=%h instr=%h, expected none", instrPc, instr);
         end else begin
            e = exp_q.pop_front();
            chk("instrPc", instrPc, e.pc);
            chk("instr", instr, e.instr);
            chk1("instrCompressed", instrCompressed, e.c);
         end
      end
      if (!rst && reqValid && reqReady) begin
         chk("outstanding_at_accept", 32'(pend_q.size()), 32'd0);
         p.addr = reqAddr;
         p.due  = cyc + mem_lat;
         pend_q.push_back(p);
         req_log.push_back(reqAddr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) pend_q.delete();
      rspValid = 1'b0;
      rspData  = $urandom;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         p        = pend_q.pop_front();
         rspValid = 1'b1;
         rspData  = mem[p.addr[11:2]];
      end
      if (auto_stop && exp_q.size() == 0) instrReady = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirectValid = 1'b1;
      redirectPc    = pc;
      #1;
      chk1("reqValid_in_redirect", reqValid, 1'b0);
      tick();
      redirectValid = 1'b0;
      redirectPc    = $urandom;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_accept(input int budget);
      int n0;
      n0 = req_log.size();
      for (int i = 0; i < budget && req_log.size() == n0; i++) tick();
      if (req_log.size() == n0) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got no request, expected one");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n0;
      vec_t v;
      logic [31:0] a;

      n_checks = 0; n_errors = 0; cyc = 0; mem_lat = 1; auto_stop = 1'b0;
      rst = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0;
      reqReady = 1'b1; rspValid = 1'b0; rspData = 32'h0; instrReady = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;

`ifdef FETCH_RVC_EN
      tbl[0] = mk(32'h0, 32'h0, 32'h0, 32'h4501_4501, 32'h0000_0013, 32'h13, 32'h13, 2'd3,
                  32'h0, 32'h4501, 1'b1, 32'h2, 32'h4501, 1'b1, 32'h4, 32'h13, 1'b0);
      tbl[1] = mk(32'h100, 32'h100, 32'h100, 32'h0013_4501, 32'h1234_0000, 32'h13, 32'h13, 2'd3,
                  32'h100, 32'h4501, 1'b1, 32'h102, 32'h13, 1'b0, 32'h106, 32'h1234, 1'b1);
      tbl[2] = mk(32'h202, 32'h200, 32'h200, 32'h4589_FFFF, 32'h00B0_0593, 32'h13, 32'h13, 2'd2,
                  32'h202, 32'h4589, 1'b1, 32'h204, 32'h00B0_0593, 1'b0, 32'h0, 32'h0, 1'b0);
      tbl[3] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0013_4501, 32'h4501_0000,
                  32'h13, 32'h13, 2'd2,
                  32'hFFFF_FFFE, 32'h13, 1'b0, 32'h2, 32'h4501, 1'b1, 32'h0, 32'h0, 1'b0);
`else
      tbl[0] = mk(32'h100, 32'h100, 32'h100, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                  32'h0040_0213, 2'd3,
                  32'h100, 32'h0010_0093, 1'b0, 32'h104, 32'h0020_0113, 1'b0,
                  32'h108, 32'h0030_0193, 1'b0);
      tbl[1] = mk(32'h206, 32'h200, 32'h204, 32'h0AA0_0513, 32'h0BB0_0593, 32'h0CC0_0613,
                  32'h0DD0_0693, 2'd2,
                  32'h204, 32'h0BB0_0593, 1'b0, 32'h208, 32'h0CC0_0613, 1'b0, 32'h0, 32'h0, 1'b0);
      tbl[2] = mk(32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0E00_0E13, 32'h0F00_0F13,
                  32'h0100_0013, 32'h0200_0013, 2'd3,
                  32'hFFFF_FFF8, 32'h0E00_0E13, 1'b0, 32'hFFFF_FFFC, 32'h0F00_0F13, 1'b0,
                  32'h0, 32'h0100_0013, 1'b0);
      tbl[3] = mk(32'h302, 32'h300, 32'h300, 32'h4501_4501, 32'h0013_4501, 32'h13, 32'h13, 2'd2,
                  32'h300, 32'h4501_4501, 1'b0, 32'h304, 32'h0013_4501, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

      // ---- reset state and first request
      repeat (3) tick();
      chk1("rst_reqValid", reqValid, 1'b0);
      chk("rst_reqAddr", reqAddr, 32'h0);
      chk1("rst_instrValid", instrValid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instrPc", instrPc, 32'h0);
      chk1("rst_instrCompressed", instrCompressed, 1'b0);
      rst = 1'b0;
      #1;
      chk1("first_reqValid", reqValid, 1'b1);
      chk("first_reqAddr", reqAddr, 32'h0);

      // ---- sequential stream of 32-bit words from reset
      push_exp(32'h0, 32'h13, 1'b0);
      push_exp(32'h4, 32'h13, 1'b0);
      push_exp(32'h8, 32'h13, 1'b0);
      instrReady = 1'b1;
      auto_stop  = 1'b1;
      wait_drain(100);
      chk("stream_req0", log_at(0), 32'h0);
      chk("stream_req1", log_at(1), 32'h4);
      chk("stream_req2", log_at(2), 32'h8);

      // ---- table of redirect targets
      for (int i = 0; i < 4; i++) begin
         v = tbl[i];
         for (int k = 0; k < 4; k++) begin
            a = v.base + 32'(4 * k);
            mem_put(a, v.w[k]);
         end
         n0 = req_log.size();
         do_redirect(v.pc);
         for (int k = 0; k < 3; k++) begin
            if (k < int'(v.n)) push_exp(v.epc[k], v.ein[k], v.ec[k]);
         end
         instrReady = 1'b1;
         wait_drain(200);
         chk("vec_first_req", log_at(n0), v.ereq);
         chk("vec_second_req", log_at(n0 + 1), v.ereq + 32'd4);
      end

      // ---- redirect while a request is in flight: stale word dropped
      mem_lat = 3;
      mem_put(32'h400, 32'hDEAD_BEEF);
      mem_put(32'h404, 32'hDEAD_BEEF);
      mem_put(32'h100, 32'hABCD_4501);
      mem_put(32'h104, 32'h0050_0293);
      do_redirect(32'h400);
      wait_accept(20);
      n0 = req_log.size();
      do_redirect(32'h102);
`ifdef FETCH_RVC_EN
      push_exp(32'h102, 32'h0000_ABCD, 1'b1);
`else
      push_exp(32'h100, 32'hABCD_4501, 1'b0);
`endif
      push_exp(32'h104, 32'h0050_0293, 1'b0);
      instrReady = 1'b1;
      wait_drain(100);
      chk("drop_next_req", log_at(n0), 32'h100);
      mem_lat = 1;

      // ---- redirect in the same cycle as the response
      mem_put(32'h300, 32'h00A0_0513);
      mem_put(32'h304, 32'h00B0_0593);
      do_redirect(32'h400);
      wait_accept(20);
      n0 = req_log.size();
      do_redirect(32'h300);
      #1;
      chk1("rsp_in_redirect_reqValid", reqValid, 1'b1);
      chk("rsp_in_redirect_reqAddr", reqAddr, 32'h300);
      push_exp(32'h300, 32'h00A0_0513, 1'b0);
      push_exp(32'h304, 32'h00B0_0593, 1'b0);
      instrReady = 1'b1;
      wait_drain(100);
      chk("rsp_in_redirect_req", log_at(n0), 32'h300);

      // ---- decode stall: output holds steady
      mem_put(32'h500, 32'h0010_0093);
      mem_put(32'h504, 32'h0020_0113);
      mem_put(32'h508, 32'h0030_0193);
      do_redirect(32'h500);
      push_exp(32'h500, 32'h0010_0093, 1'b0);
      push_exp(32'h504, 32'h0020_0113, 1'b0);
      push_exp(32'h508, 32'h0030_0193, 1'b0);
      instrReady = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("stall_valid", instrValid, 1'b1);
         chk("stall_pc", instrPc, 32'h500);
         chk("stall_instr", instr, 32'h0010_0093);
      end
      instrReady = 1'b1;
      wait_drain(100);

      // ---- reset in the middle of a fetch
      mem_lat = 2;
      do_redirect(32'h500);
      wait_accept(20);
      rst = 1'b1;
      tick();
      chk1("midrst_instrValid", instrValid, 1'b0);
      chk1("midrst_reqValid", reqValid, 1'b0);
      chk("midrst_instrPc", instrPc, 32'h0);
      chk("midrst_reqAddr", reqAddr, 32'h0);
      rst = 1'b0;
      #1;
      chk1("midrst_first_reqValid", reqValid, 1'b1);
      chk("midrst_first_reqAddr", reqAddr, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fetch_aligner
`default_nettype wire
